// File: rtl/tod_pkg.sv
// Shared BCD types, digit limits, load FSM states and time validation for time_of_day_counter.
package tod_pkg;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t h1;
        bcd_t h0;
        bcd_t m1;
        bcd_t m0;
        bcd_t s1;
        bcd_t s0;
    } tod_t;

    localparam bcd_t DIGIT_MAX = 4'd9;
    localparam bcd_t TENS_MAX  = 4'd5;

    typedef enum logic {
        S_READY = 1'b0,
        S_APPLY = 1'b1
    } tod_state_e;

    // BCD compare of the hour pair equals binary compare once both digits are <= 9.
    function automatic logic tod_valid(input tod_t t, input logic [7:0] hour_wrap);
        logic [7:0] hh;
        hh = {t.h1, t.h0};
        return (t.s1 <= TENS_MAX) && (t.s0 <= DIGIT_MAX) &&
               (t.m1 <= TENS_MAX) && (t.m0 <= DIGIT_MAX) &&
               (t.h1 <= DIGIT_MAX) && (t.h0 <= DIGIT_MAX) && (hh < hour_wrap);
    endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit wrapping MAX->0 with carry; clear beats load beats inc, new value next cycle.
module bcd_digit_counter
    import tod_pkg::*;
#(
    parameter bcd_t MAX     = DIGIT_MAX,
    parameter bcd_t RST_VAL = 4'd0
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic load,
    input  bcd_t load_val,
    input  logic inc,
    output bcd_t value,
    output bcd_t value_nxt,
    output logic carry_out
);

    bcd_t val_q, val_d;

    always_comb begin
        val_d = val_q;
        if (clear) begin
            val_d = 4'd0;
        end else if (load) begin
            val_d = load_val;
        end else if (inc) begin
            val_d = (val_q == MAX) ? 4'd0 : val_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            val_q <= RST_VAL;
        end else begin
            val_q <= val_d;
        end
    end

    assign value     = val_q;
    assign value_nxt = val_d;
    assign carry_out = inc && (val_q == MAX);

endmodule

// File: rtl/time_of_day_counter.sv
// BCD hh:mm:ss clock: tick shows next cycle; load shows 2 cycles after accept.
// load_ready drops for the one-cycle apply, so at most one load every 2 cycles.
module time_of_day_counter
    import tod_pkg::*;
#(
    parameter logic [23:0] RESET_TIME = 24'h000000,
    parameter logic [7:0]  HOUR_WRAP  = 8'h24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        run,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [23:0] load_time,
    input  logic        alarm_en,
    input  logic [23:0] alarm_time,
    output logic [23:0] time_bcd,
    output logic        min_tick,
    output logic        day_tick,
    output logic        alarm,
    output logic        load_err
);

    tod_state_e state_q, state_d;
    tod_t       cap_q, cap_d;
    logic       load_ready_q, load_ready_d;
    logic       pending_q, pending_d;
    logic       load_err_q, load_err_d;
    logic       min_tick_q, min_tick_d;
    logic       day_tick_q, day_tick_d;
    logic       alarm_q, alarm_d;

    logic       accept, apply, apply_ok, inc, hr_wrap;
    logic       c_s0, c_s1, c_m0, c_m1, c_h0, c_h1;
    bcd_t       s0, s1, m0, m1, h0, h1;
    bcd_t       s0_n, s1_n, m0_n, m1_n, h0_n, h1_n;
    logic [7:0] hour_inc;

    bcd_digit_counter #(.MAX(DIGIT_MAX), .RST_VAL(RESET_TIME[3:0])) u_s0 (
        .clk(clk), .rst(rst), .clear(1'b0), .load(apply_ok), .load_val(cap_q.s0),
        .inc(inc), .value(s0), .value_nxt(s0_n), .carry_out(c_s0));
    bcd_digit_counter #(.MAX(TENS_MAX), .RST_VAL(RESET_TIME[7:4])) u_s1 (
        .clk(clk), .rst(rst), .clear(1'b0), .load(apply_ok), .load_val(cap_q.s1),
        .inc(c_s0), .value(s1), .value_nxt(s1_n), .carry_out(c_s1));
    bcd_digit_counter #(.MAX(DIGIT_MAX), .RST_VAL(RESET_TIME[11:8])) u_m0 (
        .clk(clk), .rst(rst), .clear(1'b0), .load(apply_ok), .load_val(cap_q.m0),
        .inc(c_s1), .value(m0), .value_nxt(m0_n), .carry_out(c_m0));
    bcd_digit_counter #(.MAX(TENS_MAX), .RST_VAL(RESET_TIME[15:12])) u_m1 (
        .clk(clk), .rst(rst), .clear(1'b0), .load(apply_ok), .load_val(cap_q.m1),
        .inc(c_m0), .value(m1), .value_nxt(m1_n), .carry_out(c_m1));
    bcd_digit_counter #(.MAX(DIGIT_MAX), .RST_VAL(RESET_TIME[19:16])) u_h0 (
        .clk(clk), .rst(rst), .clear(hr_wrap), .load(apply_ok), .load_val(cap_q.h0),
        .inc(c_m1), .value(h0), .value_nxt(h0_n), .carry_out(c_h0));
    bcd_digit_counter #(.MAX(HOUR_WRAP[7:4]), .RST_VAL(RESET_TIME[23:20])) u_h1 (
        .clk(clk), .rst(rst), .clear(hr_wrap), .load(apply_ok), .load_val(cap_q.h1),
        .inc(c_h0), .value(h1), .value_nxt(h1_n), .carry_out(c_h1));

    always_comb begin
        accept   = load_valid && load_ready_q;
        apply    = (state_q == S_APPLY);
        apply_ok = apply && tod_valid(cap_q, HOUR_WRAP);
        // A pending tick and a fresh tick collapse into one increment.
        inc      = (state_q == S_READY) && !accept && run && (tick || pending_q);

        hour_inc = (h0 == DIGIT_MAX) ? {h1 + 4'd1, 4'd0} : {h1, h0 + 4'd1};
        hr_wrap  = c_m1 && ((hour_inc == HOUR_WRAP) || c_h1);

        state_d = state_q;
        if (accept) begin
            state_d = S_APPLY;
        end else if (apply) begin
            state_d = S_READY;
        end
        load_ready_d = (state_d == S_READY);
        cap_d        = accept ? tod_t'(load_time) : cap_q;
        pending_d    = run && apply && tick;
        load_err_d   = apply && !apply_ok;
        min_tick_d   = c_s1;
        day_tick_d   = hr_wrap;
        alarm_d      = inc && alarm_en &&
                       ({h1_n, h0_n, m1_n, m0_n, s1_n, s0_n} == alarm_time);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_READY;
            cap_q        <= '0;
            load_ready_q <= 1'b0;
            pending_q    <= 1'b0;
            load_err_q   <= 1'b0;
            min_tick_q   <= 1'b0;
            day_tick_q   <= 1'b0;
            alarm_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cap_q        <= cap_d;
            load_ready_q <= load_ready_d;
            pending_q    <= pending_d;
            load_err_q   <= load_err_d;
            min_tick_q   <= min_tick_d;
            day_tick_q   <= day_tick_d;
            alarm_q      <= alarm_d;
        end
    end

    assign time_bcd   = {h1, h0, m1, m0, s1, s0};
    assign load_ready = load_ready_q;
    assign load_err   = load_err_q;
    assign min_tick   = min_tick_q;
    assign day_tick   = day_tick_q;
    assign alarm      = alarm_q;

endmodule

// File: tb/tb_time_of_day_counter.sv
// Table-driven bench for time_of_day_counter with RESET_TIME=23:59:58 and a 24-hour wrap.
module tb_time_of_day_counter;

    logic        clk = 1'b0;
    logic        rst, tick, run, load_valid, alarm_en;
    logic [23:0] load_time, alarm_time;
    logic        load_ready, min_tick, day_tick, alarm, load_err;
    logic [23:0] time_bcd;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    time_of_day_counter #(
        .RESET_TIME(24'h235958),
        .HOUR_WRAP (8'h24)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .run       (run),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .load_time (load_time),
        .alarm_en  (alarm_en),
        .alarm_time(alarm_time),
        .time_bcd  (time_bcd),
        .min_tick  (min_tick),
        .day_tick  (day_tick),
        .alarm     (alarm),
        .load_err  (load_err)
    );

    typedef struct {
        logic        tk;
        logic        rn;
        logic        lv;
        logic [23:0] lt;
        logic        aen;
        logic [23:0] at;
        logic [23:0] e_time;
        logic        e_min;
        logic        e_day;
        logic        e_alm;
        logic        e_err;
        logic        e_rdy;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic tk, input logic rn, input logic lv, input logic [23:0] lt,
                       input logic aen, input logic [23:0] at, input logic [23:0] et,
                       input logic emin, input logic eday, input logic ealm,
                       input logic eerr, input logic erdy);
        vec_t v;
        v.tk = tk; v.rn = rn; v.lv = lv; v.lt = lt; v.aen = aen; v.at = at;
        v.e_time = et; v.e_min = emin; v.e_day = eday; v.e_alm = ealm;
        v.e_err = eerr; v.e_rdy = erdy;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [23:0] act,
                       input logic [23:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s[%0d] got=%h expected=%h", name, idx, act, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; run = 1'b0; load_valid = 1'b0;
        load_time = '0; alarm_en = 1'b0; alarm_time = '0;

        // tk rn lv load_time   aen alarm_time  exp_time    min day alm err rdy
        add(0, 1, 0, 24'h000000, 0, 24'h000000, 24'h235958, 0, 0, 0, 0, 1);
        add(1, 1, 0, 24'h000000, 0, 24'h000000, 24'h235959, 0, 0, 0, 0, 1);
        add(1, 1, 0, 24'h000000, 0, 24'h000000, 24'h000000, 1, 1, 0, 0, 1);
        add(0, 1, 0, 24'h000000, 0, 24'h000000, 24'h000000, 0, 0, 0, 0, 1);
        add(0, 1, 1, 24'h125930, 0, 24'h000000, 24'h000000, 0, 0, 0, 0, 0);
        add(1, 1, 0, 24'h000000, 0, 24'h000000, 24'h125930, 0, 0, 0, 0, 1);
        add(0, 1, 0, 24'h000000, 0, 24'h000000, 24'h125931, 0, 0, 0, 0, 1);
        add(0, 1, 0, 24'h000000, 0, 24'h000000, 24'h125931, 0, 0, 0, 0, 1);
        add(1, 1, 1, 24'h010203, 0, 24'h000000, 24'h125931, 0, 0, 0, 0, 0);
        add(0, 1, 0, 24'h000000, 0, 24'h000000, 24'h010203, 0, 0, 0, 0, 1);
        add(0, 1, 1, 24'h246000, 0, 24'h000000, 24'h010203, 0, 0, 0, 0, 0);
        add(0, 1, 1, 24'h246000, 0, 24'h000000, 24'h010203, 0, 0, 0, 1, 1);
        add(0, 1, 0, 24'h000000, 0, 24'h000000, 24'h010203, 0, 0, 0, 0, 1);
        add(0, 1, 1, 24'h005960, 0, 24'h000000, 24'h010203, 0, 0, 0, 0, 0);
        add(1, 1, 0, 24'h000000, 0, 24'h000000, 24'h010203, 0, 0, 0, 1, 1);
        add(1, 1, 0, 24'h000000, 0, 24'h000000, 24'h010204, 0, 0, 0, 0, 1);
        add(0, 1, 0, 24'h000000, 0, 24'h000000, 24'h010204, 0, 0, 0, 0, 1);
        add(0, 1, 1, 24'h000958, 0, 24'h000000, 24'h010204, 0, 0, 0, 0, 0);
        add(1, 0, 0, 24'h000000, 0, 24'h000000, 24'h000958, 0, 0, 0, 0, 1);
        add(0, 1, 0, 24'h000000, 0, 24'h000000, 24'h000958, 0, 0, 0, 0, 1);
        add(1, 1, 0, 24'h000000, 0, 24'h000000, 24'h000959, 0, 0, 0, 0, 1);
        add(0, 1, 1, 24'h000000, 1, 24'h000010, 24'h000959, 0, 0, 0, 0, 0);
        add(0, 1, 0, 24'h000000, 1, 24'h000010, 24'h000000, 0, 0, 0, 0, 1);
        for (int k = 1; k <= 10; k++) begin
            add(1, 1, 0, 24'h000000, 1, 24'h000010,
                (k == 10) ? 24'h000010 : 24'(k), 0, 0, (k == 10), 0, 1);
        end
        add(1, 0, 0, 24'h000000, 1, 24'h000010, 24'h000010, 0, 0, 0, 0, 1);
        add(1, 0, 0, 24'h000000, 1, 24'h000010, 24'h000010, 0, 0, 0, 0, 1);
        add(1, 1, 0, 24'h000000, 1, 24'h000010, 24'h000011, 0, 0, 0, 0, 1);
        add(0, 1, 1, 24'h000010, 1, 24'h000010, 24'h000011, 0, 0, 0, 0, 0);
        add(0, 1, 0, 24'h000000, 1, 24'h000010, 24'h000010, 0, 0, 0, 0, 1);
        add(0, 1, 0, 24'h000000, 1, 24'h000010, 24'h000010, 0, 0, 0, 0, 1);
        add(0, 1, 1, 24'h000009, 0, 24'h000010, 24'h000010, 0, 0, 0, 0, 0);
        add(0, 1, 0, 24'h000000, 0, 24'h000010, 24'h000009, 0, 0, 0, 0, 1);
        add(1, 1, 0, 24'h000000, 0, 24'h000010, 24'h000010, 0, 0, 0, 0, 1);
        add(0, 1, 1, 24'h000059, 0, 24'h000000, 24'h000010, 0, 0, 0, 0, 0);
        add(0, 1, 0, 24'h000000, 0, 24'h000000, 24'h000059, 0, 0, 0, 0, 1);
        for (int k = 0; k < 5; k++) begin
            add(1, 0, 0, 24'h000000, 0, 24'h000000, 24'h000059, 0, 0, 0, 0, 1);
        end
        add(1, 1, 0, 24'h000000, 0, 24'h000000, 24'h000100, 1, 0, 0, 0, 1);
        add(1, 1, 0, 24'h000000, 0, 24'h000000, 24'h000101, 0, 0, 0, 0, 1);
        add(1, 1, 0, 24'h000000, 0, 24'h000000, 24'h000102, 0, 0, 0, 0, 1);
        add(0, 1, 1, 24'h095959, 0, 24'h000000, 24'h000102, 0, 0, 0, 0, 0);
        add(0, 1, 0, 24'h000000, 0, 24'h000000, 24'h095959, 0, 0, 0, 0, 1);
        add(1, 1, 0, 24'h000000, 0, 24'h000000, 24'h100000, 1, 0, 0, 0, 1);
        add(0, 1, 1, 24'h125959, 0, 24'h000000, 24'h100000, 0, 0, 0, 0, 0);
        add(0, 1, 0, 24'h000000, 0, 24'h000000, 24'h125959, 0, 0, 0, 0, 1);
        add(1, 1, 0, 24'h000000, 0, 24'h000000, 24'h130000, 1, 0, 0, 0, 1);
        add(0, 1, 1, 24'h240000, 0, 24'h000000, 24'h130000, 0, 0, 0, 0, 0);
        add(0, 1, 0, 24'h000000, 0, 24'h000000, 24'h130000, 0, 0, 0, 1, 1);
        add(0, 1, 1, 24'h195959, 0, 24'h000000, 24'h130000, 0, 0, 0, 0, 0);
        add(0, 1, 0, 24'h000000, 0, 24'h000000, 24'h195959, 0, 0, 0, 0, 1);
        add(1, 1, 0, 24'h000000, 0, 24'h000000, 24'h200000, 1, 0, 0, 0, 1);

        // Reset state
        step();
        step();
        chk("rst_time", 0, time_bcd, 24'h235958);
        chk("rst_ready", 0, 24'(load_ready), 24'h0);
        chk("rst_min", 0, 24'(min_tick), 24'h0);
        chk("rst_day", 0, 24'(day_tick), 24'h0);
        chk("rst_alarm", 0, 24'(alarm), 24'h0);
        chk("rst_err", 0, 24'(load_err), 24'h0);
        rst = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            vec_t v;
            v = vq[i];
            tick = v.tk; run = v.rn; load_valid = v.lv; load_time = v.lt;
            alarm_en = v.aen; alarm_time = v.at;
            step();
            chk("time", i, time_bcd, v.e_time);
            chk("min_tick", i, 24'(min_tick), 24'(v.e_min));
            chk("day_tick", i, 24'(day_tick), 24'(v.e_day));
            chk("alarm", i, 24'(alarm), 24'(v.e_alm));
            chk("load_err", i, 24'(load_err), 24'(v.e_err));
            chk("load_ready", i, 24'(load_ready), 24'(v.e_rdy));
        end

        // Reset landing on the apply cycle of a load of 10:10:10
        tick = 1'b0; run = 1'b1; alarm_en = 1'b0;
        load_valid = 1'b1; load_time = 24'h101010;
        step();
        chk("mid_accept_ready", 0, 24'(load_ready), 24'h0);
        load_valid = 1'b0; rst = 1'b1;
        step();
        chk("mid_rst_time", 0, time_bcd, 24'h235958);
        chk("mid_rst_err", 0, 24'(load_err), 24'h0);
        chk("mid_rst_ready", 0, 24'(load_ready), 24'h0);
        rst = 1'b0;
        step();
        chk("post_rst_ready", 0, 24'(load_ready), 24'h1);
        chk("post_rst_time", 0, time_bcd, 24'h235958);
        chk("post_rst_err", 0, 24'(load_err), 24'h0);
        step();
        chk("post_rst_time", 1, time_bcd, 24'h235958);
        chk("post_rst_err", 1, 24'(load_err), 24'h0);
        tick = 1'b1;
        step();
        tick = 1'b0;
        chk("post_rst_tick", 0, time_bcd, 24'h235959);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
